// File: rtl/serial_tx_frame.sv
// Parallel-to-serial frame transmitter: start bit (0), DATA_W data bits LSB first, stop bit (1),
// with every line bit held for CLKS_PER_BIT clocks. A word is taken through a valid/ready handshake.
module serial_tx_frame #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic              Clk,
    input  logic              Resetn,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              tx_done
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_shift;
    logic [BIT_W-1:0]    r_bit;
    logic [BAUD_W-1:0]   r_baud;
    logic                r_out;
    logic                r_busy;
    logic                r_done;
    logic                w_bit_end;
    logic                w_last_bit;
    logic                w_pre_end;

    assign w_bit_end  = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
    assign w_pre_end  = (r_baud == BAUD_W'(CLKS_PER_BIT - 2));
    assign w_last_bit = (r_bit == BIT_W'(DATA_W - 1));

    assign tx_ready = (r_state == ST_IDLE);
    assign tx_out   = r_out;
    assign busy     = r_busy;
    assign tx_done  = r_done;

    // Frame sequencer; the shift register is consumed from bit 0 at each bit boundary.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= ST_IDLE;
            r_shift <= '0;
            r_bit   <= '0;
            r_baud  <= '0;
            r_out   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_baud <= '0;
                    r_bit  <= '0;
                    r_out  <= 1'b1;
                    if (tx_valid) begin
                        r_shift <= tx_data;
                        r_state <= ST_START;
                        r_out   <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_state <= ST_DATA;
                        r_out   <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (w_last_bit) begin
                            r_state <= ST_STOP;
                            r_out   <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + BIT_W'(1);
                            r_out   <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                ST_STOP: begin
                    // tx_done is registered one cycle early so it lands in the final stop cycle.
                    r_done <= w_pre_end;
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_out   <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx_frame.sv
// Directed bench for serial_tx_frame: default 8-bit/4-clock instance plus a 4-bit/2-clock corner instance.
module tb_serial_tx_frame;

    logic       Clk;
    logic       Resetn;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_out;
    logic       busy;
    logic       tx_done;

    logic [3:0] b_data;
    logic       b_valid;
    logic       b_ready;
    logic       b_out;
    logic       b_busy;
    logic       b_done;

    int n_total;
    int n_bad;

    serial_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(4)) u_dut (
        .Clk      (Clk),
        .Resetn   (Resetn),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_out   (tx_out),
        .busy     (busy),
        .tx_done  (tx_done)
    );

    serial_tx_frame #(.DATA_W(4), .CLKS_PER_BIT(2)) u_dut_small (
        .Clk      (Clk),
        .Resetn   (Resetn),
        .tx_data  (b_data),
        .tx_valid (b_valid),
        .tx_ready (b_ready),
        .tx_out   (b_out),
        .busy     (b_busy),
        .tx_done  (b_done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Expand a per-bit line pattern (bit i = line bit i) to per-cycle values.
    function automatic logic [39:0] expand4(input logic [9:0] g);
        logic [39:0] r;
        for (int c = 0; c < 40; c++) r[c] = g[c / 4];
        return r;
    endfunction

    function automatic logic [11:0] expand2(input logic [5:0] g);
        logic [11:0] r;
        for (int c = 0; c < 12; c++) r[c] = g[c / 2];
        return r;
    endfunction

    // Accept one word, optionally change tx_data afterwards, and record 40 cycles of outputs.
    task automatic run_frame(input logic [7:0] d, input logic [7:0] d_after, input logic hold,
                             output logic [39:0] line, output logic [39:0] done,
                             output int busy_cnt, output int rdy_cnt);
        busy_cnt = 0;
        rdy_cnt  = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        tick();
        if (!hold) tx_valid = 1'b0;
        tx_data = d_after;
        for (int c = 0; c < 40; c++) begin
            line[c] = tx_out;
            done[c] = tx_done;
            if (busy) busy_cnt++;
            if (tx_ready) rdy_cnt++;
            tick();
        end
    endtask

    logic [39:0] line;
    logic [39:0] done;
    logic [11:0] line_s;
    logic [11:0] done_s;
    int          bcnt;
    int          rcnt;

    initial begin
        n_total  = 0;
        n_bad    = 0;
        Resetn   = 1'b1;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        b_data   = 4'h0;
        b_valid  = 1'b0;

        // Reset takes effect without any clock edge.
        #1 Resetn = 1'b0;
        #1;
        check_val("rst_out",   64'(tx_out),   64'd1);
        check_val("rst_ready", 64'(tx_ready), 64'd1);
        check_val("rst_busy",  64'(busy),     64'd0);
        check_val("rst_done",  64'(tx_done),  64'd0);
        #1 Resetn = 1'b1;
        tick();
        tick();
        check_val("idle_out", 64'(tx_out), 64'd1);

        // Single frame 0xA5.
        run_frame(8'hA5, 8'hA5, 1'b0, line, done, bcnt, rcnt);
        check_val("a5_line",  64'(line), 64'(expand4(10'b1101001010)));
        check_val("a5_done",  64'(done), 64'h80_0000_0000);
        check_val("a5_busy",  64'(bcnt), 64'd40);
        check_val("a5_ready", 64'(rcnt), 64'd0);
        check_val("a5_rdy41", 64'(tx_ready), 64'd1);
        check_val("a5_out41", 64'(tx_out),   64'd1);
        check_val("a5_bsy41", 64'(busy),     64'd0);
        tick();

        // tx_data changes after accept must not reach the line.
        run_frame(8'h3C, 8'hFF, 1'b0, line, done, bcnt, rcnt);
        check_val("3c_line", 64'(line), 64'(expand4(10'b1001111000)));
        check_val("3c_done", 64'(done), 64'h80_0000_0000);
        tick();

        // Back-to-back with tx_valid held: one idle-high cycle between frames.
        run_frame(8'h00, 8'h00, 1'b1, line, done, bcnt, rcnt);
        check_val("b2b0_line",  64'(line), 64'(expand4(10'b1000000000)));
        check_val("b2b0_busy",  64'(bcnt), 64'd40);
        check_val("b2b0_ready", 64'(rcnt), 64'd0);
        check_val("gap_out",    64'(tx_out),   64'd1);
        check_val("gap_ready",  64'(tx_ready), 64'd1);
        run_frame(8'hFF, 8'hFF, 1'b0, line, done, bcnt, rcnt);
        check_val("b2b1_line", 64'(line), 64'(expand4(10'b1111111110)));
        check_val("b2b1_done", 64'(done), 64'h80_0000_0000);
        check_val("b2b1_busy", 64'(bcnt), 64'd40);
        tick();

        // Mid-frame reset during data bit 3 of 0x55 (line low there).
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int c = 0; c < 17; c++) tick();
        check_val("mid_pre_out", 64'(tx_out), 64'd0);
        #2 Resetn = 1'b0;
        #1;
        check_val("mid_rst_out",   64'(tx_out),   64'd1);
        check_val("mid_rst_ready", 64'(tx_ready), 64'd1);
        check_val("mid_rst_busy",  64'(busy),     64'd0);
        #1 Resetn = 1'b1;
        tick();
        run_frame(8'h81, 8'h81, 1'b0, line, done, bcnt, rcnt);
        check_val("81_line", 64'(line), 64'(expand4(10'b1100000010)));
        check_val("81_done", 64'(done), 64'h80_0000_0000);
        tick();

        // Parameter corner: 4 data bits, 2 clocks per bit, word 0xB.
        b_data  = 4'hB;
        b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        bcnt    = 0;
        for (int c = 0; c < 12; c++) begin
            line_s[c] = b_out;
            done_s[c] = b_done;
            if (b_busy) bcnt++;
            tick();
        end
        check_val("sm_line",  64'(line_s), 64'(expand2(6'b110110)));
        check_val("sm_done",  64'(done_s), 64'h800);
        check_val("sm_busy",  64'(bcnt),   64'd12);
        check_val("sm_ready", 64'(b_ready), 64'd1);
        check_val("sm_out",   64'(b_out),   64'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
